// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: run control, instruction ROM port, decode handshake and status.
// The master modport is the fetch controller side; slave is the core/loader/ROM side.
interface fetch_ctrl_if;
  logic        start;
  logic        halt;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        br_taken;
  logic [63:0] br_target;
  logic        f_valid;
  logic        f_ready;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    input  start, halt, imem_instr, br_taken, br_target, f_ready,
    output imem_addr, f_valid, f_pc, f_instr, fault, fault_pc, fetch_count
  );

  modport slave (
    output start, halt, imem_instr, br_taken, br_target, f_ready,
    input  imem_addr, f_valid, f_pc, f_instr, fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, captures ROM words into a one-entry
// valid/ready output register, applies redirects and parks in a sticky fault state.
module fetch_ctrl #(
  parameter int unsigned IMEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        f_valid_q;
  logic [63:0] f_pc_q;
  logic [31:0] f_instr_q;
  logic        fault_q;
  logic [63:0] fault_pc_q;
  logic [31:0] fetch_count_q;

  // The last byte of the word is checked in 65 bits so a PC near 2^64 cannot wrap into range.
  logic [64:0] pc_end_s;
  logic        bad_pc_s;
  logic        accept_s;
  logic        slot_free_s;

  assign pc_end_s    = {1'b0, pc_q} + 65'd3;
  assign bad_pc_s    = (pc_q[1:0] != 2'b00) || (pc_end_s >= 65'(IMEM_SIZE));
  assign accept_s    = f_valid_q & bus.f_ready;
  assign slot_free_s = ~f_valid_q | bus.f_ready;

  assign bus.imem_addr   = pc_q;
  assign bus.f_valid     = f_valid_q;
  assign bus.f_pc        = f_pc_q;
  assign bus.f_instr     = f_instr_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = fetch_count_q;

  // Control FSM with PC, output register and status held in the same process.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      f_valid_q     <= 1'b0;
      f_pc_q        <= 64'd0;
      f_instr_q     <= 32'd0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 64'd0;
      fetch_count_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) f_valid_q <= 1'b0;
          if (bus.br_taken) pc_q <= bus.br_target;
          if (bus.start && !bus.halt) state_q <= RUN;
        end
        RUN: begin
          if (bus.halt) begin
            state_q <= IDLE;
            if (accept_s) f_valid_q <= 1'b0;
          end else if (bus.br_taken) begin
            pc_q      <= bus.br_target;
            f_valid_q <= 1'b0;
          end else if (bad_pc_s) begin
            state_q    <= FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
            f_valid_q  <= 1'b0;
          end else if (slot_free_s) begin
            f_instr_q     <= bus.imem_instr;
            f_pc_q        <= pc_q;
            f_valid_q     <= 1'b1;
            pc_q          <= pc_q + 64'd4;
            fetch_count_q <= fetch_count_q + 32'd1;
          end else begin
            f_valid_q <= f_valid_q;
          end
        end
        FAULT: begin
          f_valid_q <= 1'b0;
        end
        default: begin
          // Corrupted state encoding is treated as a fetch fault.
          state_q    <= FAULT;
          fault_q    <= 1'b1;
          fault_pc_q <= pc_q;
          f_valid_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; the ROM returns {16'hC0DE, 6'd0, word index}.
module tb_fetch_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .IMEM_SIZE (1024),
    .RESET_PC  (64'd0)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.master)
  );

  assign bus.imem_instr = {16'hC0DE, 6'd0, bus.imem_addr[11:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 64'd0;
    bus.f_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(bus.f_valid), 64'd0);
    chk("rst_fpc", bus.f_pc, 64'd0);
    chk("rst_finstr", 64'(bus.f_instr), 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_faultpc", bus.fault_pc, 64'd0);
    chk("rst_count", 64'(bus.fetch_count), 64'd0);
    chk("rst_addr", bus.imem_addr, 64'd0);

    // Startup and streaming
    reset = 1'b0;
    bus.start = 1'b1;
    bus.f_ready = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_lat_valid", 64'(bus.f_valid), 64'd0);
    step();
    chk("s0_valid", 64'(bus.f_valid), 64'd1);
    chk("s0_pc", bus.f_pc, 64'd0);
    chk("s0_instr", 64'(bus.f_instr), 64'hC0DE0000);
    step();
    chk("s1_pc", bus.f_pc, 64'd4);
    chk("s1_instr", 64'(bus.f_instr), 64'hC0DE0001);
    step();
    chk("s2_pc", bus.f_pc, 64'd8);
    chk("s2_instr", 64'(bus.f_instr), 64'hC0DE0002);
    step();
    chk("s3_pc", bus.f_pc, 64'd12);
    chk("s3_instr", 64'(bus.f_instr), 64'hC0DE0003);
    chk("s3_count", 64'(bus.fetch_count), 64'd4);
    chk("s3_addr", bus.imem_addr, 64'd16);

    // Backpressure for three cycles
    bus.f_ready = 1'b0;
    step();
    step();
    step();
    chk("stall_valid", 64'(bus.f_valid), 64'd1);
    chk("stall_pc", bus.f_pc, 64'd12);
    chk("stall_instr", 64'(bus.f_instr), 64'hC0DE0003);
    chk("stall_addr", bus.imem_addr, 64'd16);
    chk("stall_count", 64'(bus.fetch_count), 64'd4);
    bus.f_ready = 1'b1;
    step();
    chk("release_pc", bus.f_pc, 64'd16);
    chk("release_instr", 64'(bus.f_instr), 64'hC0DE0004);
    chk("release_count", 64'(bus.fetch_count), 64'd5);

    // Redirect in the same cycle as an accepting handshake
    bus.br_taken = 1'b1;
    bus.br_target = 64'h40;
    step();
    bus.br_taken = 1'b0;
    chk("br_flush_valid", 64'(bus.f_valid), 64'd0);
    chk("br_addr", bus.imem_addr, 64'h40);
    chk("br_count", 64'(bus.fetch_count), 64'd5);
    step();
    chk("br_tgt_valid", 64'(bus.f_valid), 64'd1);
    chk("br_tgt_pc", bus.f_pc, 64'h40);
    chk("br_tgt_instr", 64'(bus.f_instr), 64'hC0DE0010);
    chk("br_tgt_count", 64'(bus.fetch_count), 64'd6);

    // Halt with a held instruction, drain in IDLE, resume
    bus.f_ready = 1'b0;
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    step();
    chk("halt_valid", 64'(bus.f_valid), 64'd1);
    chk("halt_pc", bus.f_pc, 64'h40);
    chk("halt_addr", bus.imem_addr, 64'h44);
    chk("halt_count", 64'(bus.fetch_count), 64'd6);
    bus.f_ready = 1'b1;
    step();
    chk("idle_drain_valid", 64'(bus.f_valid), 64'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("resume_pc", bus.f_pc, 64'h44);
    chk("resume_instr", 64'(bus.f_instr), 64'hC0DE0011);
    chk("resume_count", 64'(bus.fetch_count), 64'd7);

    // Reset mid-RUN with a held instruction and a pending redirect
    chk("pre_rst_valid", 64'(bus.f_valid), 64'd1);
    reset = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 64'h80;
    step();
    reset = 1'b0;
    bus.br_taken = 1'b0;
    chk("mid_rst_valid", 64'(bus.f_valid), 64'd0);
    chk("mid_rst_fpc", bus.f_pc, 64'd0);
    chk("mid_rst_instr", 64'(bus.f_instr), 64'd0);
    chk("mid_rst_count", 64'(bus.fetch_count), 64'd0);
    chk("mid_rst_addr", bus.imem_addr, 64'd0);

    // Misaligned entry point loaded from IDLE
    bus.br_taken = 1'b1;
    bus.br_target = 64'h42;
    bus.start = 1'b1;
    step();
    bus.br_taken = 1'b0;
    bus.start = 1'b0;
    step();
    chk("mis_fault", 64'(bus.fault), 64'd1);
    chk("mis_fault_pc", bus.fault_pc, 64'h42);
    chk("mis_valid", 64'(bus.f_valid), 64'd0);
    chk("mis_count", 64'(bus.fetch_count), 64'd0);
    bus.start = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 64'h0;
    step();
    step();
    bus.start = 1'b0;
    bus.br_taken = 1'b0;
    chk("sticky_fault", 64'(bus.fault), 64'd1);
    chk("sticky_addr", bus.imem_addr, 64'h42);
    chk("sticky_valid", 64'(bus.f_valid), 64'd0);

    // Last in-range word, then one past the end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_fault", 64'(bus.fault), 64'd0);
    bus.start = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 64'h3FC;
    step();
    bus.start = 1'b0;
    bus.br_taken = 1'b0;
    step();
    chk("last_valid", 64'(bus.f_valid), 64'd1);
    chk("last_pc", bus.f_pc, 64'h3FC);
    chk("last_instr", 64'(bus.f_instr), 64'hC0DE00FF);
    chk("last_fault", 64'(bus.fault), 64'd0);
    step();
    chk("oob_fault", 64'(bus.fault), 64'd1);
    chk("oob_fault_pc", bus.fault_pc, 64'h400);
    chk("oob_valid", 64'(bus.f_valid), 64'd0);
    chk("oob_count", 64'(bus.fetch_count), 64'd1);

    // Top of the address space must not wrap into range
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    bus.start = 1'b0;
    bus.br_taken = 1'b0;
    step();
    chk("top_fault", 64'(bus.fault), 64'd1);
    chk("top_fault_pc", bus.fault_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_valid", 64'(bus.f_valid), 64'd0);
    chk("top_count", 64'(bus.fetch_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
